// File: rtl/link_pkg.sv
// Shared types for the FTDI link arbiter: byte type, client-id type and default response length.
package link_pkg;

    localparam int unsigned NCLI_MAX    = 4;
    localparam int unsigned CID_W       = $clog2(NCLI_MAX);
    localparam int unsigned RSP_LEN_DEF = 8;

    typedef logic [7:0]       byte_t;
    typedef logic [CID_W-1:0] cid_t;

endpackage

// File: rtl/link_tag_fifo.sv
// Synchronous FIFO of client IDs; records grant order so responses return to the right client.
module link_tag_fifo
    import link_pkg::*;
#(
    parameter int unsigned TAG_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic                        pop,
    input  cid_t                        din,
    output cid_t                        dout,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(TAG_DEPTH):0]  count
);

    localparam int unsigned AW = $clog2(TAG_DEPTH);
    localparam int unsigned CW = AW + 1;

    cid_t          mem_q [TAG_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == CW'(TAG_DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/ftdi_link_arb.sv
// Shares one FTDI cmd/res FIFO pair between NCLI clients: packet-level round-robin on requests,
// in-order routing of fixed-length responses using a FIFO of grant IDs.
module ftdi_link_arb
    import link_pkg::*;
#(
    parameter int unsigned NCLI      = 2,
    parameter int unsigned RSP_LEN   = RSP_LEN_DEF,
    parameter int unsigned TAG_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NCLI-1:0]             req_valid,
    input  logic [NCLI*8-1:0]           req_data,
    input  logic [NCLI-1:0]             req_last,
    output logic [NCLI-1:0]             req_ready,
    output logic [NCLI-1:0]             rsp_valid,
    output byte_t                       rsp_data,
    output logic                        rsp_last,
    input  logic                        cmd_almost_full,
    output logic                        cmd_wr_en,
    output byte_t                       cmd_din,
    input  logic                        res_almost_empty,
    output logic                        res_rd_en,
    input  byte_t                       res_dout,
    output logic [$clog2(TAG_DEPTH):0]  outstanding,
    output logic                        busy
);

    localparam int unsigned RCW = $clog2(RSP_LEN + 1);

    typedef enum logic { S_IDLE, S_XFER } req_state_e;
    typedef enum logic { R_IDLE, R_READ } rsp_state_e;

    req_state_e             req_state_q, req_state_d;
    cid_t                   grant_q, grant_d;
    cid_t                   rr_q, rr_d;
    logic                   cmd_wr_en_q, cmd_wr_en_d;
    byte_t                  cmd_din_q, cmd_din_d;
    rsp_state_e             rsp_state_q, rsp_state_d;
    logic [RCW-1:0]         remain_q, remain_d;
    logic [NCLI-1:0]        rsp_valid_q, rsp_valid_d;
    logic                   rsp_last_q, rsp_last_d;

    logic                   pick_vld;
    cid_t                   pick;
    logic                   sel_valid;
    logic                   sel_last;
    byte_t                  sel_data;
    logic                   tag_push;
    logic                   tag_pop;
    cid_t                   tag_head;
    logic                   tag_full;
    logic                   tag_empty;
    logic [$clog2(TAG_DEPTH):0] tag_count;
    logic                   rd_en_c;

    link_tag_fifo #(.TAG_DEPTH(TAG_DEPTH)) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tag_push),
        .pop   (tag_pop),
        .din   (grant_q),
        .dout  (tag_head),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

    // First valid client at or after the round-robin pointer
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        for (int k = 0; k < int'(NCLI); k++) begin
            for (int i = 0; i < int'(NCLI); i++) begin
                if (!pick_vld && req_valid[i] && (32'(i) == (32'(rr_q) + 32'(k)) % NCLI)) begin
                    pick_vld = 1'b1;
                    pick     = cid_t'(i);
                end
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < int'(NCLI); i++) begin
            if (grant_q == cid_t'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[8*i +: 8];
            end
        end
    end

    // Request FSM: grant one client per packet and forward its bytes to the cmd FIFO
    always_comb begin
        req_state_d = req_state_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        cmd_wr_en_d = 1'b0;
        cmd_din_d   = cmd_din_q;
        req_ready   = '0;
        tag_push    = 1'b0;
        case (req_state_q)
            S_IDLE: begin
                if (pick_vld && !tag_full) begin
                    req_state_d = S_XFER;
                    grant_d     = pick;
                    rr_d        = cid_t'((32'(pick) + 32'd1) % NCLI);
                end
            end
            S_XFER: begin
                for (int i = 0; i < int'(NCLI); i++) begin
                    req_ready[i] = (grant_q == cid_t'(i)) && !cmd_almost_full;
                end
                if (sel_valid && !cmd_almost_full) begin
                    cmd_wr_en_d = 1'b1;
                    cmd_din_d   = sel_data;
                    if (sel_last) begin
                        tag_push    = 1'b1;
                        req_state_d = S_IDLE;
                    end
                end
            end
            default: req_state_d = S_IDLE;
        endcase
    end

    // Response FSM: read RSP_LEN bytes for the head tag, pop it on the last delivered byte
    always_comb begin
        rsp_state_d = rsp_state_q;
        remain_d    = remain_q;
        rsp_valid_d = '0;
        rsp_last_d  = 1'b0;
        rd_en_c     = 1'b0;
        tag_pop     = 1'b0;
        case (rsp_state_q)
            R_IDLE: begin
                if (!tag_empty) begin
                    rsp_state_d = R_READ;
                    remain_d    = RCW'(RSP_LEN);
                end
            end
            R_READ: begin
                if ((remain_q != '0) && !res_almost_empty) begin
                    rd_en_c    = 1'b1;
                    remain_d   = remain_q - RCW'(1);
                    rsp_last_d = (remain_q == RCW'(1));
                    for (int i = 0; i < int'(NCLI); i++) begin
                        rsp_valid_d[i] = (tag_head == cid_t'(i));
                    end
                end
                if (rsp_last_q) begin
                    tag_pop     = 1'b1;
                    rsp_state_d = R_IDLE;
                end
            end
            default: rsp_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_state_q <= S_IDLE;
            grant_q     <= '0;
            rr_q        <= '0;
            cmd_wr_en_q <= 1'b0;
            cmd_din_q   <= '0;
            rsp_state_q <= R_IDLE;
            remain_q    <= '0;
            rsp_valid_q <= '0;
            rsp_last_q  <= 1'b0;
        end else begin
            req_state_q <= req_state_d;
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            cmd_wr_en_q <= cmd_wr_en_d;
            cmd_din_q   <= cmd_din_d;
            rsp_state_q <= rsp_state_d;
            remain_q    <= remain_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    // res_dout is valid the cycle after a read, which is exactly when rsp_valid_q is high
    assign rsp_data    = (|rsp_valid_q) ? res_dout : '0;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_last    = rsp_last_q;
    assign cmd_wr_en   = cmd_wr_en_q;
    assign cmd_din     = cmd_din_q;
    assign res_rd_en   = rd_en_c;
    assign outstanding = tag_count;
    assign busy        = (req_state_q == S_XFER) || (tag_count != '0);

endmodule

// File: tb/tb_ftdi_link_arb.sv
// Directed bench for ftdi_link_arb (NCLI=2, RSP_LEN=8, TAG_DEPTH=4) with a non-FWFT res FIFO model.
module tb_ftdi_link_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [15:0] req_data = '0;
    logic [1:0]  req_last = '0;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_last;
    logic        cmd_almost_full = 1'b0;
    logic        cmd_wr_en;
    logic [7:0]  cmd_din;
    logic        res_almost_empty = 1'b1;
    logic        res_rd_en;
    logic [7:0]  res_dout = '0;
    logic [2:0]  outstanding;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [7:0]  res_q [$];
    logic [7:0]  cmd_q [$];
    logic [10:0] rsp_q [$];

    ftdi_link_arb #(.NCLI(2), .RSP_LEN(8), .TAG_DEPTH(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_last         (req_last),
        .req_ready        (req_ready),
        .rsp_valid        (rsp_valid),
        .rsp_data         (rsp_data),
        .rsp_last         (rsp_last),
        .cmd_almost_full  (cmd_almost_full),
        .cmd_wr_en        (cmd_wr_en),
        .cmd_din          (cmd_din),
        .res_almost_empty (res_almost_empty),
        .res_rd_en        (res_rd_en),
        .res_dout         (res_dout),
        .outstanding      (outstanding),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    // res FIFO model: data one cycle after rd_en, almost_empty when nothing is queued
    always @(posedge clk) begin
        if (res_rd_en) begin
            if (res_q.size() != 0) res_dout <= res_q.pop_front();
            else                   res_dout <= 8'hEE;
        end
        res_almost_empty <= (res_q.size() == 0);
    end

    always @(posedge clk) begin
        if (rst_n && cmd_wr_en) cmd_q.push_back(cmd_din);
        if (rst_n && (rsp_valid != 2'b00)) rsp_q.push_back({rsp_valid, rsp_last, rsp_data});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0; req_data = '0; req_last = '0; cmd_almost_full = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        res_q.delete(); cmd_q.delete(); rsp_q.delete();
    endtask

    task automatic send1(input int c, input logic [7:0] d, output bit ok);
        logic acc;
        ok = 1'b0;
        req_valid = 2'b01 << c;
        req_last  = 2'b01 << c;
        req_data[8*c +: 8] = d;
        for (int cyc = 0; cyc < 20 && !ok; cyc++) begin
            #1;
            acc = req_ready[c];
            @(negedge clk);
            if (acc) ok = 1'b1;
        end
        req_valid = '0;
        req_last  = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
        checks++; if ({cmd_wr_en, cmd_din} !== 9'h000) begin errors++; $display("FAIL reset_cmd: got wr=%b din=%h want 0/00", cmd_wr_en, cmd_din); end
        checks++; if ({rsp_valid, rsp_last, rsp_data} !== 11'h000) begin errors++; $display("FAIL reset_rsp: got v=%b l=%b d=%h want 0", rsp_valid, rsp_last, rsp_data); end
        checks++; if (res_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", res_rd_en); end
        checks++; if ({outstanding, busy} !== 4'h0) begin errors++; $display("FAIL reset_status: got out=%0d busy=%b want 0/0", outstanding, busy); end
    endtask

    task automatic test_single();
        req_valid = 2'b01; req_data[7:0] = 8'hA1; req_last = 2'b00;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL single_grant_cycle: got ready=%b want 00", req_ready); end
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b want 01", req_ready); end
        checks++; if (cmd_wr_en !== 1'b0) begin errors++; $display("FAIL single_no_early_wr: got %b want 0", cmd_wr_en); end
        for (int b = 0; b < 3; b++) begin
            req_data[7:0] = 8'hA1 + 8'(b);
            req_last[0]   = (b == 2);
            @(negedge clk);
            checks++;
            if (cmd_wr_en !== 1'b1 || cmd_din !== 8'hA1 + 8'(b)) begin
                errors++; $display("FAIL single_wr%0d: got wr=%b din=%h want 1/%h", b, cmd_wr_en, cmd_din, 8'hA1 + 8'(b));
            end
        end
        checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL single_outstanding: got %0d want 1", outstanding); end
        checks++; if (req_ready !== 2'b00 || busy !== 1'b1) begin errors++; $display("FAIL single_after_last: got ready=%b busy=%b want 00/1", req_ready, busy); end
        req_valid = '0; req_last = '0;
        @(negedge clk);
        checks++; if (cmd_wr_en !== 1'b0) begin errors++; $display("FAIL single_wr_idle: got %b want 0", cmd_wr_en); end
        for (int i = 0; i < 8; i++) res_q.push_back(8'h10 + 8'(i));
        for (int i = 0; i < 100 && outstanding != 0; i++) @(negedge clk);
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL single_drain: got outstanding=%0d want 0", outstanding); end
        checks++; if (rsp_q.size() != 8) begin errors++; $display("FAIL single_rsp_count: got %0d want 8", rsp_q.size()); end
        for (int i = 0; i < rsp_q.size() && i < 8; i++) begin
            checks++;
            if (rsp_q[i] !== {2'b01, (i == 7), 8'h10 + 8'(i)}) begin
                errors++; $display("FAIL single_rsp%0d: got %h want %h", i, rsp_q[i], {2'b01, (i == 7), 8'h10 + 8'(i)});
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_round_robin();
        int idx [2];
        logic [1:0] acc;
        logic [7:0] exp_b [8];
        exp_b = '{8'h01, 8'h02, 8'h81, 8'h82, 8'h03, 8'h04, 8'h83, 8'h84};
        idx = '{0, 0};
        for (int cyc = 0; cyc < 60 && (idx[0] < 4 || idx[1] < 4); cyc++) begin
            for (int c = 0; c < 2; c++) begin
                req_valid[c] = (idx[c] < 4);
                req_data[8*c +: 8] = ((c == 1) ? 8'h80 : 8'h00) + 8'(idx[c] + 1);
                req_last[c] = (idx[c] % 2 == 1);
            end
            #1;
            acc = req_valid & req_ready;
            @(negedge clk);
            for (int c = 0; c < 2; c++) if (acc[c]) idx[c]++;
        end
        req_valid = '0; req_last = '0;
        repeat (2) @(negedge clk);
        checks++; if (cmd_q.size() != 8) begin errors++; $display("FAIL rr_count: got %0d want 8", cmd_q.size()); end
        for (int i = 0; i < cmd_q.size() && i < 8; i++) begin
            checks++;
            if (cmd_q[i] !== exp_b[i]) begin errors++; $display("FAIL rr_byte%0d: got %h want %h", i, cmd_q[i], exp_b[i]); end
        end
        checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL rr_outstanding: got %0d want 4", outstanding); end
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int hold = 0;
        logic acc;
        for (int cyc = 0; cyc < 80 && idx < 6; cyc++) begin
            req_valid[0] = 1'b1;
            req_data[7:0] = 8'h31 + 8'(idx);
            req_last[0] = (idx == 5);
            cmd_almost_full = (idx == 2 && hold < 5);
            #1;
            if (cmd_almost_full) begin
                hold++;
                checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_ready%0d: got %b want 00", hold, req_ready); end
                if (hold > 1) begin
                    checks++; if (cmd_wr_en !== 1'b0) begin errors++; $display("FAIL bp_no_wr%0d: got %b want 0", hold, cmd_wr_en); end
                end
            end
            acc = req_valid[0] & req_ready[0];
            @(negedge clk);
            if (acc) idx++;
        end
        req_valid = '0; req_last = '0; cmd_almost_full = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (hold != 5) begin errors++; $display("FAIL bp_hold: got %0d cycles want 5", hold); end
        checks++; if (cmd_q.size() != 6) begin errors++; $display("FAIL bp_count: got %0d want 6", cmd_q.size()); end
        for (int i = 0; i < cmd_q.size() && i < 6; i++) begin
            checks++;
            if (cmd_q[i] !== 8'h31 + 8'(i)) begin errors++; $display("FAIL bp_byte%0d: got %h want %h", i, cmd_q[i], 8'h31 + 8'(i)); end
        end
    endtask

    task automatic test_ordering();
        bit ok;
        logic [1:0] exp_v;
        send1(1, 8'h55, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ord_send1: got no accept want accept"); end
        send1(0, 8'h66, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ord_send0: got no accept want accept"); end
        @(negedge clk);
        checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL ord_outstanding: got %0d want 2", outstanding); end
        checks++; if (cmd_q.size() != 2 || cmd_q[0] !== 8'h55 || cmd_q[1] !== 8'h66) begin
            errors++; $display("FAIL ord_cmd: got size %0d want 55,66", cmd_q.size());
        end
        for (int i = 0; i < 16; i++) res_q.push_back(8'h40 + 8'(i));
        for (int i = 0; i < 150 && outstanding != 0; i++) @(negedge clk);
        checks++; if (rsp_q.size() != 16) begin errors++; $display("FAIL ord_rsp_count: got %0d want 16", rsp_q.size()); end
        for (int i = 0; i < rsp_q.size() && i < 16; i++) begin
            exp_v = (i < 8) ? 2'b10 : 2'b01;
            checks++;
            if (rsp_q[i] !== {exp_v, (i % 8 == 7), 8'h40 + 8'(i)}) begin
                errors++; $display("FAIL ord_rsp%0d: got %h want %h", i, rsp_q[i], {exp_v, (i % 8 == 7), 8'h40 + 8'(i)});
            end
        end
    endtask

    task automatic test_tag_full();
        bit ok;
        for (int p = 0; p < 4; p++) begin
            send1(0, 8'h70 + 8'(p), ok);
            checks++; if (!ok) begin errors++; $display("FAIL full_send%0d: got no accept want accept", p); end
        end
        checks++; if (outstanding !== 3'd4 || busy !== 1'b1) begin errors++; $display("FAIL full_level: got out=%0d busy=%b want 4/1", outstanding, busy); end
        req_valid = 2'b10; req_last = 2'b10; req_data[15:8] = 8'h99;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL full_blocked%0d: got %b want 00", i, req_ready); end
        end
        for (int i = 0; i < 8; i++) res_q.push_back(8'h50 + 8'(i));
        for (int i = 0; i < 60 && outstanding == 3'd4; i++) @(negedge clk);
        checks++; if (outstanding !== 3'd3) begin errors++; $display("FAIL full_pop: got %0d want 3", outstanding); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL full_grant_cycle: got %b want 00", req_ready); end
        @(negedge clk);
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL full_granted: got %b want 10", req_ready); end
        @(negedge clk);
        req_valid = '0; req_last = '0;
        checks++; if (cmd_wr_en !== 1'b1 || cmd_din !== 8'h99 || outstanding !== 3'd4) begin
            errors++; $display("FAIL full_fifth: got wr=%b din=%h out=%0d want 1/99/4", cmd_wr_en, cmd_din, outstanding);
        end
        checks++; if (rsp_q.size() != 8) begin errors++; $display("FAIL full_rsp_count: got %0d want 8", rsp_q.size()); end
        else begin
            checks++; if (rsp_q[7] !== {2'b01, 1'b1, 8'h57}) begin errors++; $display("FAIL full_rsp_last: got %h want %h", rsp_q[7], {2'b01, 1'b1, 8'h57}); end
        end
    endtask

    task automatic test_reset_midop();
        bit ok;
        send1(1, 8'h11, ok);
        checks++; if (!ok) begin errors++; $display("FAIL midop_send: got no accept want accept"); end
        for (int i = 0; i < 3; i++) res_q.push_back(8'h21 + 8'(i));
        req_valid = 2'b01; req_data[7:0] = 8'hC1; req_last = 2'b00;
        for (int i = 0; i < 40 && rsp_q.size() < 3; i++) @(negedge clk);
        checks++; if (rsp_q.size() != 3) begin errors++; $display("FAIL midop_partial: got %0d want 3", rsp_q.size()); end
        checks++; if (req_ready !== 2'b01 || cmd_wr_en !== 1'b1 || outstanding !== 3'd1) begin
            errors++; $display("FAIL midop_active: got ready=%b wr=%b out=%0d want 01/1/1", req_ready, cmd_wr_en, outstanding);
        end
        rst_n = 1'b0;
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL midop_req_ready: got %b want 00", req_ready); end
        checks++; if ({cmd_wr_en, cmd_din} !== 9'h000) begin errors++; $display("FAIL midop_cmd: got wr=%b din=%h want 0/00", cmd_wr_en, cmd_din); end
        checks++; if ({rsp_valid, rsp_last, rsp_data} !== 11'h000 || res_rd_en !== 1'b0) begin
            errors++; $display("FAIL midop_rsp: got v=%b l=%b d=%h rd=%b want 0", rsp_valid, rsp_last, rsp_data, res_rd_en);
        end
        checks++; if ({outstanding, busy} !== 4'h0) begin errors++; $display("FAIL midop_status: got out=%0d busy=%b want 0/0", outstanding, busy); end
        req_valid = '0; req_last = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        res_q.delete(); cmd_q.delete(); rsp_q.delete();
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL midop_release: got %0d want 0", outstanding); end
    endtask

    initial begin
        test_reset();
        do_reset();
        test_single();
        do_reset();
        test_round_robin();
        do_reset();
        test_backpressure();
        do_reset();
        test_ordering();
        do_reset();
        test_tag_full();
        do_reset();
        test_reset_midop();
        test_single();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
